// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of renamed instructions.
// Entries are allocated in program order at the tail and marked done out of
// order by writeback. The head retires once done. An excepting head raises a
// one-cycle flush that empties the buffer on the following edge.
module reorder_buffer #(
    parameter int ROB_SIZE  = 16,
    parameter int PRN_WIDTH = 6,
    parameter int ARN_WIDTH = 5,
    parameter int PC_SIZE   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic                          alloc_writes_rd,
    input  logic [ARN_WIDTH-1:0]          alloc_rd_arch,
    input  logic [PRN_WIDTH-1:0]          alloc_p_new,
    input  logic [PRN_WIDTH-1:0]          alloc_p_old,
    input  logic [PC_SIZE-1:0]            alloc_pc,
    output logic [$clog2(ROB_SIZE)-1:0]   alloc_idx,
    input  logic                          wb_valid,
    input  logic [$clog2(ROB_SIZE)-1:0]   wb_idx,
    input  logic                          wb_exception,
    output logic                          commit_valid,
    input  logic                          commit_ready,
    output logic                          commit_writes_rd,
    output logic [ARN_WIDTH-1:0]          commit_rd_arch,
    output logic [PRN_WIDTH-1:0]          commit_p_new,
    output logic [PRN_WIDTH-1:0]          commit_p_old,
    output logic                          flush_valid,
    output logic [PC_SIZE-1:0]            flush_pc,
    output logic [$clog2(ROB_SIZE):0]     count
);

    localparam int IW = $clog2(ROB_SIZE);
    localparam int PW = IW + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [IW-1:0]        head_idx;
    logic [IW-1:0]        tail_idx;

    logic [ROB_SIZE-1:0]  valid_q;
    logic [ROB_SIZE-1:0]  done_q;
    logic [ROB_SIZE-1:0]  exc_q;
    logic [ROB_SIZE-1:0]  writes_q;
    logic [ARN_WIDTH-1:0] rd_arch_q [ROB_SIZE];
    logic [PRN_WIDTH-1:0] p_new_q   [ROB_SIZE];
    logic [PRN_WIDTH-1:0] p_old_q   [ROB_SIZE];
    logic [PC_SIZE-1:0]   pc_q      [ROB_SIZE];

    logic full;
    logic head_done;
    logic alloc_fire;
    logic commit_fire;

    assign head_idx = head[IW-1:0];
    assign tail_idx = tail[IW-1:0];
    assign full     = (head_idx == tail_idx) && (head[IW] != tail[IW]);
    assign count    = tail - head;

    // Head decode uses registered state only, so commit/flush never see inputs.
    assign head_done    = valid_q[head_idx] && done_q[head_idx];
    assign commit_valid = head_done && !exc_q[head_idx];
    assign flush_valid  = head_done && exc_q[head_idx];
    assign flush_pc     = pc_q[head_idx];

    assign commit_writes_rd = writes_q[head_idx];
    assign commit_rd_arch   = rd_arch_q[head_idx];
    assign commit_p_new     = p_new_q[head_idx];
    assign commit_p_old     = p_old_q[head_idx];

    // A full buffer does not look at a same-cycle commit; that keeps alloc_ready
    // independent of commit_ready at the cost of one stall cycle.
    assign alloc_ready = !full && !flush_valid;
    assign alloc_idx   = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = commit_valid && commit_ready;

    // Head/tail pointer update; a flush rewinds both to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush_valid) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (alloc_fire)  tail <= tail + PW'(1);
            if (commit_fire) head <= head + PW'(1);
        end
    end

    // Per-entry status bits: allocation, writeback completion and retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else if (flush_valid) begin
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            if (wb_valid && valid_q[wb_idx]) begin
                done_q[wb_idx] <= 1'b1;
                exc_q[wb_idx]  <= wb_exception;
            end
            if (commit_fire) valid_q[head_idx] <= 1'b0;
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                exc_q[tail_idx]   <= 1'b0;
            end
        end
    end

    // Entry payload, captured at allocation; cleared on reset so head outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writes_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_arch_q[i] <= '0;
                p_new_q[i]   <= '0;
                p_old_q[i]   <= '0;
                pc_q[i]      <= '0;
            end
        end else if (alloc_fire) begin
            writes_q[tail_idx]  <= alloc_writes_rd;
            rd_arch_q[tail_idx] <= alloc_rd_arch;
            p_new_q[tail_idx]   <= alloc_p_new;
            p_old_q[tail_idx]   <= alloc_p_old;
            pc_q[tail_idx]      <= alloc_pc;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit/flush scoreboard.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic        alloc_writes_rd;
    logic [4:0]  alloc_rd_arch;
    logic [5:0]  alloc_p_new;
    logic [5:0]  alloc_p_old;
    logic [63:0] alloc_pc;
    logic [3:0]  alloc_idx;
    logic        wb_valid;
    logic [3:0]  wb_idx;
    logic        wb_exception;
    logic        commit_valid;
    logic        commit_ready;
    logic        commit_writes_rd;
    logic [4:0]  commit_rd_arch;
    logic [5:0]  commit_p_new;
    logic [5:0]  commit_p_old;
    logic        flush_valid;
    logic [63:0] flush_pc;
    logic [4:0]  count;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_writes_rd  (alloc_writes_rd),
        .alloc_rd_arch    (alloc_rd_arch),
        .alloc_p_new      (alloc_p_new),
        .alloc_p_old      (alloc_p_old),
        .alloc_pc         (alloc_pc),
        .alloc_idx        (alloc_idx),
        .wb_valid         (wb_valid),
        .wb_idx           (wb_idx),
        .wb_exception     (wb_exception),
        .commit_valid     (commit_valid),
        .commit_ready     (commit_ready),
        .commit_writes_rd (commit_writes_rd),
        .commit_rd_arch   (commit_rd_arch),
        .commit_p_new     (commit_p_new),
        .commit_p_old     (commit_p_old),
        .flush_valid      (flush_valid),
        .flush_pc         (flush_pc),
        .count            (count)
    );

    typedef struct packed {
        logic       wr;
        logic [4:0] rd;
        logic [5:0] pnew;
        logic [5:0] pold;
    } cexp_t;

    cexp_t       exp_q[$];
    logic [63:0] flush_q[$];
    int          checks = 0;
    int          failures = 0;
    int          commits_seen = 0;
    int          flushes_seen = 0;
    int          seq = 0;
    logic        prev_flush = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic       f_wr(int s);   return (s % 3) != 0;       endfunction
    function automatic logic [4:0] f_rd(int s);   return 5'(s * 7 + 1);      endfunction
    function automatic logic [5:0] f_pnew(int s); return 6'(s * 3 + 32);     endfunction
    function automatic logic [5:0] f_pold(int s); return 6'(s * 5 + 1);      endfunction
    function automatic logic [63:0] f_pc(int s);  return 64'h1000 + 64'(s * 4); endfunction

    // Scoreboard monitor: commits pop expected payload, flushes pop expected pc.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count_bound", count <= 5'd16, 1);
            if (flush_valid) begin
                chk("flush_one_cycle", prev_flush, 0);
                chk("flush_commit_valid", commit_valid, 0);
                chk("flush_expected", flush_q.size() != 0, 1);
                if (flush_q.size() != 0) chk("flush_pc", flush_pc, flush_q.pop_front());
                exp_q.delete();
                flushes_seen++;
            end
            if (commit_valid && commit_ready) begin
                chk("commit_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cexp_t e;
                    e = exp_q.pop_front();
                    chk("commit_writes_rd", commit_writes_rd, e.wr);
                    chk("commit_rd_arch", commit_rd_arch, e.rd);
                    chk("commit_p_new", commit_p_new, e.pnew);
                    chk("commit_p_old", commit_p_old, e.pold);
                end
                commits_seen++;
            end
            prev_flush = flush_valid;
        end else begin
            prev_flush = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; holds alloc_valid until accepted (bounded).
    task automatic alloc_one(input logic [63:0] pc, input logic [5:0] pnew, input logic [5:0] pold,
                             input logic [4:0] rd, input logic wr, output logic [3:0] idx);
        bit ok = 0;
        alloc_valid = 1'b1;
        alloc_pc = pc; alloc_p_new = pnew; alloc_p_old = pold;
        alloc_rd_arch = rd; alloc_writes_rd = wr;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (alloc_ready) begin ok = 1; break; end
        end
        idx = alloc_idx;
        chk("alloc_accept", ok, 1);
        step();
        alloc_valid = 1'b0;
        if (ok) exp_q.push_back('{wr, rd, pnew, pold});
    endtask

    task automatic alloc_seq(output logic [3:0] idx);
        alloc_one(f_pc(seq), f_pnew(seq), f_pold(seq), f_rd(seq), f_wr(seq), idx);
        seq++;
    endtask

    task automatic wb(input logic [3:0] idx, input logic exc);
        wb_valid = 1'b1; wb_idx = idx; wb_exception = exc;
        step();
        wb_valid = 1'b0; wb_exception = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] idx;
        rst_n = 1'b0;
        alloc_valid = 0; alloc_writes_rd = 0; alloc_rd_arch = '0;
        alloc_p_new = '0; alloc_p_old = '0; alloc_pc = '0;
        wb_valid = 0; wb_idx = '0; wb_exception = 0; commit_ready = 0;

        // Reset values
        #12;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_flush_valid", flush_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_alloc_idx", alloc_idx, 0);
        chk("rst_commit_p_old", commit_p_old, 0);
        chk("rst_flush_pc", flush_pc, 0);
        step();
        rst_n = 1'b1;

        // Fill all 16 entries with no writeback
        for (int i = 0; i < 16; i++) begin
            alloc_seq(idx);
            chk("fill_alloc_idx", idx, i);
        end
        @(negedge clk);
        chk("fill_count", count, 16);
        chk("fill_alloc_ready", alloc_ready, 0);
        chk("fill_commit_valid", commit_valid, 0);

        // Out-of-order writeback 3, 1, 0; commits 0 and 1 then stall on 2
        step();
        commit_ready = 1'b1;
        wb(3, 0);
        @(negedge clk);
        chk("wb3_no_commit", commit_valid, 0);
        step();
        wb(1, 0);
        @(negedge clk);
        chk("wb1_no_commit", commit_valid, 0);
        step();
        wb(0, 0);
        @(negedge clk);
        chk("wb0_commit_valid", commit_valid, 1);
        repeat (4) @(negedge clk);
        chk("ooo_commits", commits_seen, 2);
        chk("ooo_count", count, 14);
        chk("ooo_stall", commit_valid, 0);

        // Full ROB: simultaneous commit and alloc; alloc waits one cycle
        step();
        commit_ready = 1'b0;
        alloc_seq(idx);
        chk("refill_idx0", idx, 0);
        alloc_seq(idx);
        chk("refill_idx1", idx, 1);
        wb(2, 0);
        @(negedge clk);
        chk("full_count", count, 16);
        chk("full_alloc_ready", alloc_ready, 0);
        chk("full_head_valid", commit_valid, 1);
        step();
        alloc_valid = 1'b1;
        alloc_pc = f_pc(seq); alloc_p_new = f_pnew(seq); alloc_p_old = f_pold(seq);
        alloc_rd_arch = f_rd(seq); alloc_writes_rd = f_wr(seq);
        commit_ready = 1'b1;
        @(negedge clk);
        chk("full_alloc_stall", alloc_ready, 0);
        chk("full_alloc_idx", alloc_idx, 2);
        step();
        commit_ready = 1'b0;
        @(negedge clk);
        chk("full_count_after_commit", count, 15);
        chk("full_alloc_ready_next", alloc_ready, 1);
        step();
        alloc_valid = 1'b0;
        exp_q.push_back('{f_wr(seq), f_rd(seq), f_pnew(seq), f_pold(seq)});
        seq++;
        @(negedge clk);
        chk("full_count_refilled", count, 16);
        chk("full_commits", commits_seen, 3);

        // Reset with a full buffer, then exception at head
        step();
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        chk("rst_full_count", count, 0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        commit_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc_one(64'h100 + 64'(i * 4), 6'(40 + i), 6'(20 + i), 5'(i + 1), 1'b1, idx);
            chk("exc_alloc_idx", idx, i);
        end
        flush_q.push_back(64'h100);
        wb(0, 1);
        alloc_valid = 1'b1;
        alloc_pc = 64'h200;
        @(negedge clk);
        chk("exc_flush_valid", flush_valid, 1);
        chk("exc_flush_pc", flush_pc, 64'h100);
        chk("exc_alloc_blocked", alloc_ready, 0);
        step();
        alloc_valid = 1'b0;
        @(negedge clk);
        chk("exc_flush_clear", flush_valid, 0);
        chk("exc_count", count, 0);
        chk("exc_alloc_idx_zero", alloc_idx, 0);
        chk("exc_flushes", flushes_seen, 1);

        // Stream 40 instructions with immediate writeback
        step();
        for (int i = 0; i < 40; i++) begin
            alloc_seq(idx);
            chk("wrap_alloc_idx", idx, i % 16);
            wb(idx, 0);
        end
        begin
            bit drained = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin drained = 1; break; end
            end
            chk("wrap_drained", drained, 1);
        end
        chk("wrap_commits", commits_seen, 43);

        // Writeback to an unallocated index is ignored
        step();
        alloc_seq(idx);
        chk("unalloc_head_idx", idx, 8);
        wb(12, 1);
        @(negedge clk);
        chk("unalloc_count", count, 1);
        chk("unalloc_commit_valid", commit_valid, 0);
        chk("unalloc_flush_valid", flush_valid, 0);

        // Asynchronous reset with 5 entries in flight
        step();
        commit_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alloc_seq(idx);
            chk("inflight_idx", idx, 9 + i);
        end
        wb(8, 0);
        @(negedge clk);
        chk("inflight_count", count, 5);
        chk("inflight_commit_valid", commit_valid, 1);
        step();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_commit_valid", commit_valid, 0);
        chk("async_rst_alloc_ready", alloc_ready, 1);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        alloc_seq(idx);
        chk("post_rst_idx", idx, 0);
        @(negedge clk);
        chk("post_rst_count", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
